dcache: RTL and testbench
=========================

# dcache

Per-CPU L1 data cache feeding one requester slot of the coherent `memory_control` arbiter. It serves datapath loads and stores from a direct-mapped, 8-set, 2-word-block array and fetches/writes back blocks over the `cache_control_if` cache-side signals. It answers snoops from the controller under an MSI protocol and flushes dirty lines on halt.

## Interface
- Parameters:
  - CPUID, default 0, index of this cache's slot in the controller (informational; no logic depends on it).
- Ports, datapath side:
  - CLK  in  1  clock, rising edge.
  - nRST  in  1  asynchronous, active-low reset.
  - dmemREN  in  1  load request.
  - dmemWEN  in  1  store request.
  - dmemaddr  in  32  byte address; tag [31:6], index [5:3], block offset [2], byte offset [1:0] ignored.
  - dmemstore  in  32  store data.
  - dmemload  out  32  load data, valid when dhit=1.
  - dhit  out  1  request completed this cycle.
  - halt  in  1  start flush; held high until flushed.
  - flushed  out  1  all M lines written back; sticky until reset.
- Ports, controller side:
  - dREN  out  1  block read.
  - dWEN  out  1  block write-back.
  - daddr  out  32  word address.
  - dstore  out  32  write-back / snoop data.
  - cctrans  out  1  requester: coherence transaction. Snooped: line held in M.
  - ccwrite  out  1  read-exclusive (BusRdX) request.
  - dwait  in  1  low = current word done.
  - dload  in  32  fill data.
  - ccwait  in  1  this cache is being snooped.
  - ccinv  in  1  invalidate snooped line.
  - ccsnoopaddr  in  32  snooped word address.

## Operation
- Line state is I/S/M plus a 26-bit tag and 2 data words. Reset sets all lines to I and all outputs to 0.
- Hit: index match, tag match, and state≠I. Loads hit in S or M. Stores hit only in M; the hit writes the word and asserts dhit.
- Store to an S line counts as a miss: BusRdX refetch with no write-back.
- Main FSM states: IDLE, WB1, WB2, RD1, RD2, FLUSH1, FLUSH2, FNEXT, DONE.
- IDLE:
  - Miss with victim in M → WB1.
  - Any other miss → RD1.
  - halt and no pending request → FLUSH1 at set 0.
- WB1/WB2:
  - dWEN=1, daddr={victim tag, index, offset 0/1, 2'b00}, dstore=victim word.
  - Advance on dwait=0. WB2 → RD1.
- RD1/RD2:
  - dREN=1, cctrans=1, ccwrite=dmemWEN, daddr={request tag, index, 0/1, 2'b00}.
  - On dwait=0, latch dload into word 0/1.
  - RD2 completion installs the tag with state M if the request is a store, else S. Returns to IDLE; the request then hits next cycle.
- All request outputs stay stable until dwait=0. The controller samples them one cycle late.
- Flush:
  - FLUSH1/FLUSH2 write back set i if its line is M, using the same encoding as WB; the line then goes to I.
  - FNEXT increments i. i=7 → DONE.
  - DONE holds flushed=1.
- Snoop path (combinational, active whenever ccwait=1, in any FSM state):
  - Hit in M: cctrans=1 and dstore=word[ccsnoopaddr[2]]. This overrides FSM outputs.
  - On dwait=0 with ccsnoopaddr[2]=1: line → I if ccinv, else S.
  - Hit in S with ccinv=1: line → I at that edge.
  - Miss: cctrans=0, no change.
- While ccwait=1, the FSM ignores dwait and holds state. dhit is forced to 0.

## Timing
- Load/store hit: dhit combinational, same cycle. Store data is written at the next edge.
- Clean miss: minimum RD1+RD2 plus 1 cycle hit. Dirty miss adds WB1+WB2.
- Simultaneous snoop and own request: the snoop wins, and the FSM resumes unchanged after ccwait falls.
- Snoop of a victim currently in WB: served from the array. The line remains M until WB2 completes.
- halt during a miss: the miss finishes first, then the flush starts.
- Reset mid-transaction: immediate return to IDLE, all lines I, all outputs 0.

## Structure
- cpu_types_pkg holds:
  - word_t.
  - dcachef_t: tag[25:0], idx[2:0], blkoff, bytoff[1:0].
  - msi_t enum {I, S, M}.
  - The dcache FSM state enum.
- One combinational sub-module, `dcache_snoop`, performs snoop lookup and drives cctrans/dstore overrides.

## Test plan
- Cold load 0x40: RD1/RD2 with daddr 0x40 then 0x44, cctrans=1, ccwrite=0 → line S, dhit, dmemload=dload of word 0.
- Store 0x44=0xDEAD to the S line → BusRdX with ccwrite=1, line M, reload 0x44 returns 0xDEAD.
- Load 0x240, which conflicts with dirty set 0 → WB 0x40/0x44 with 0xDEAD at 0x44, then RD 0x240/0x244.
- Snoop with ccwait=1, ccsnoopaddr 0x244, ccinv=0, line M → cctrans=1, dstore=word1, line → S after the second dwait pulse.
- Snoop with ccinv=1 on an S line while own RD1 is pending → line I, RD1 resumes with identical outputs.
- Sets 2 and 5 in M, then halt=1 → four dWEN words in set order, flushed=1, remains 1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Purpose  : Shared types for the L1 data cache: word type, cache address
//            decomposition, MSI line state and the dcache controller states.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Byte address split for an 8-set, 2-word-block direct-mapped cache.
    typedef struct packed {
        logic [25:0] tag;
        logic [2:0]  idx;
        logic        blkoff;
        logic [1:0]  bytoff;
    } dcachef_t;

    typedef enum logic [1:0] {
        I = 2'd0,
        S = 2'd1,
        M = 2'd2
    } msi_t;

    typedef enum logic [3:0] {
        DC_IDLE   = 4'd0,
        DC_WB1    = 4'd1,
        DC_WB2    = 4'd2,
        DC_RD1    = 4'd3,
        DC_RD2    = 4'd4,
        DC_FLUSH1 = 4'd5,
        DC_FLUSH2 = 4'd6,
        DC_FNEXT  = 4'd7,
        DC_DONE   = 4'd8
    } dc_state_t;

    localparam int unsigned C_DC_SETS = 8;

endpackage
`default_nettype wire

// File: rtl/dcache_snoop.sv
`default_nettype none
// ============================================================================
// Module   : dcache_snoop
// Purpose  : Combinational snoop lookup on the line selected by the snooped
//            index. Reports M/S hits and produces the cctrans/dstore values
//            that override the requester-side outputs while snooped.
// Ports    : i_ccwait      - snoop in progress
//            i_snp_tag     - tag field of the snooped address
//            i_snp_blk     - word select of the snooped address
//            i_state/i_tag/i_word0/i_word1 - contents of the indexed line
//            o_hit_m/o_hit_s - snoop hits a line in M / S
//            o_cctrans     - "line held in M" indication
//            o_dstore      - snooped word (0 when not an M hit)
// Revision : 1.0 - initial release
// ============================================================================
module dcache_snoop
    import cpu_types_pkg::*;
(
    input  logic        i_ccwait,
    input  logic [25:0] i_snp_tag,
    input  logic        i_snp_blk,
    input  msi_t        i_state,
    input  logic [25:0] i_tag,
    input  word_t       i_word0,
    input  word_t       i_word1,
    output logic        o_hit_m,
    output logic        o_hit_s,
    output logic        o_cctrans,
    output word_t       o_dstore
);

    logic w_tag_match;

    assign w_tag_match = (i_tag == i_snp_tag);
    assign o_hit_m     = i_ccwait && w_tag_match && (i_state == M);
    assign o_hit_s     = i_ccwait && w_tag_match && (i_state == S);
    assign o_cctrans   = o_hit_m;
    assign o_dstore    = o_hit_m ? (i_snp_blk ? i_word1 : i_word0) : '0;

endmodule
`default_nettype wire

// File: rtl/dcache.sv
`default_nettype none
// ============================================================================
// Module   : dcache
// Purpose  : Direct-mapped, 8-set, 2-word-block L1 data cache with MSI
//            snooping and flush-on-halt.
// Ports    : CLK/nRST                       - clock, async active-low reset
//            dmemREN/dmemWEN/dmemaddr/dmemstore/dmemload/dhit - datapath
//            halt/flushed                   - flush request / completion
//            dREN/dWEN/daddr/dstore/cctrans/ccwrite - controller requests
//            dwait/dload                    - controller handshake / fill data
//            ccwait/ccinv/ccsnoopaddr       - snoop from the controller
// Revision : 1.0 - initial release
// ============================================================================
module dcache
    import cpu_types_pkg::*;
#(
    parameter int CPUID = 0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dmemload,
    output logic        dhit,
    input  logic        halt,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    output logic        cctrans,
    output logic        ccwrite,
    input  logic        dwait,
    input  logic [31:0] dload,
    input  logic        ccwait,
    input  logic        ccinv,
    input  logic [31:0] ccsnoopaddr
);

    msi_t        r_state [C_DC_SETS];
    logic [25:0] r_tag   [C_DC_SETS];
    word_t       r_data0 [C_DC_SETS];
    word_t       r_data1 [C_DC_SETS];
    dc_state_t   r_fsm, w_fsm_nxt;
    logic [2:0]  r_fidx;
    word_t       r_fill0;

    dcachef_t    w_req, w_snp;
    logic        w_req_any, w_tag_match, w_hit, w_victim_m;
    logic        w_fill0, w_install, w_flush_inv, w_fnext, w_fclr;
    logic        w_f_cctrans;
    word_t       w_f_dstore;
    logic        w_snp_hit_m, w_snp_hit_s, w_snp_cctrans, w_snp_hold, w_snp_upd;
    word_t       w_snp_dstore;
    logic        w_unused;

    assign w_req = dmemaddr;
    assign w_snp = ccsnoopaddr;
    assign w_unused = ^{dmemaddr[1:0], ccsnoopaddr[1:0], CPUID[0]};

    assign w_req_any   = dmemREN || dmemWEN;
    assign w_tag_match = (r_tag[w_req.idx] == w_req.tag);
    assign w_victim_m  = (r_state[w_req.idx] == M) && !w_tag_match;

    // Stores only complete in M; a store to an S line is treated as a miss.
    // Nothing completes while the cache is being snooped.
    assign w_hit = (r_fsm == DC_IDLE) && !ccwait && w_tag_match &&
                   (dmemWEN ? (r_state[w_req.idx] == M)
                            : (dmemREN && r_state[w_req.idx] != I));

    assign dhit     = w_hit;
    assign dmemload = w_req.blkoff ? r_data1[w_req.idx] : r_data0[w_req.idx];
    assign flushed  = (r_fsm == DC_DONE);

    dcache_snoop u_snoop (
        .i_ccwait  (ccwait),
        .i_snp_tag (w_snp.tag),
        .i_snp_blk (w_snp.blkoff),
        .i_state   (r_state[w_snp.idx]),
        .i_tag     (r_tag[w_snp.idx]),
        .i_word0   (r_data0[w_snp.idx]),
        .i_word1   (r_data1[w_snp.idx]),
        .o_hit_m   (w_snp_hit_m),
        .o_hit_s   (w_snp_hit_s),
        .o_cctrans (w_snp_cctrans),
        .o_dstore  (w_snp_dstore)
    );

    // A victim being written back keeps its M state until the write-back ends.
    assign w_snp_hold = ((r_fsm == DC_WB1) || (r_fsm == DC_WB2)) &&
                        (w_snp.idx == w_req.idx);
    assign w_snp_upd  = !w_snp_hold &&
                        ((w_snp_hit_m && !dwait && w_snp.blkoff) ||
                         (w_snp_hit_s && ccinv));

    assign cctrans = ccwait ? w_snp_cctrans : w_f_cctrans;
    assign dstore  = w_snp_hit_m ? w_snp_dstore : w_f_dstore;

    // Next-state and request outputs; a snoop freezes every transition.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        dREN        = 1'b0;
        dWEN        = 1'b0;
        daddr       = '0;
        w_f_dstore  = '0;
        w_f_cctrans = 1'b0;
        ccwrite     = 1'b0;
        w_fill0     = 1'b0;
        w_install   = 1'b0;
        w_flush_inv = 1'b0;
        w_fnext     = 1'b0;
        w_fclr      = 1'b0;
        case (r_fsm)
            DC_IDLE: begin
                if (!ccwait) begin
                    if (w_req_any && !w_hit) begin
                        w_fsm_nxt = w_victim_m ? DC_WB1 : DC_RD1;
                    end else if (halt && !w_req_any) begin
                        w_fsm_nxt = DC_FLUSH1;
                        w_fclr    = 1'b1;
                    end
                end
            end
            DC_WB1, DC_WB2: begin
                dWEN       = 1'b1;
                daddr      = {r_tag[w_req.idx], w_req.idx, (r_fsm == DC_WB2), 2'b00};
                w_f_dstore = (r_fsm == DC_WB2) ? r_data1[w_req.idx] : r_data0[w_req.idx];
                if (!ccwait && !dwait) begin
                    w_fsm_nxt = (r_fsm == DC_WB2) ? DC_RD1 : DC_WB2;
                end
            end
            DC_RD1, DC_RD2: begin
                dREN        = 1'b1;
                w_f_cctrans = 1'b1;
                ccwrite     = dmemWEN;
                daddr       = {w_req.tag, w_req.idx, (r_fsm == DC_RD2), 2'b00};
                if (!ccwait && !dwait) begin
                    if (r_fsm == DC_RD1) begin
                        w_fill0   = 1'b1;
                        w_fsm_nxt = DC_RD2;
                    end else begin
                        w_install = 1'b1;
                        w_fsm_nxt = DC_IDLE;
                    end
                end
            end
            DC_FLUSH1, DC_FLUSH2: begin
                if (r_state[r_fidx] != M) begin
                    if (!ccwait) begin
                        w_fsm_nxt = DC_FNEXT;
                    end
                end else begin
                    dWEN       = 1'b1;
                    daddr      = {r_tag[r_fidx], r_fidx, (r_fsm == DC_FLUSH2), 2'b00};
                    w_f_dstore = (r_fsm == DC_FLUSH2) ? r_data1[r_fidx] : r_data0[r_fidx];
                    if (!ccwait && !dwait) begin
                        w_flush_inv = (r_fsm == DC_FLUSH2);
                        w_fsm_nxt   = (r_fsm == DC_FLUSH2) ? DC_FNEXT : DC_FLUSH2;
                    end
                end
            end
            DC_FNEXT: begin
                if (!ccwait) begin
                    if (r_fidx == 3'd7) begin
                        w_fsm_nxt = DC_DONE;
                    end else begin
                        w_fnext   = 1'b1;
                        w_fsm_nxt = DC_FLUSH1;
                    end
                end
            end
            DC_DONE: w_fsm_nxt = DC_DONE;
            default: w_fsm_nxt = DC_IDLE;
        endcase
    end

    // Control state and line states. FSM-side updates only happen with
    // ccwait low and snoop-side updates only with ccwait high.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            r_fsm   <= DC_IDLE;
            r_fidx  <= '0;
            r_fill0 <= '0;
            for (int k = 0; k < C_DC_SETS; k++) begin
                r_state[k] <= I;
            end
        end else begin
            r_fsm <= w_fsm_nxt;
            if (w_fclr) begin
                r_fidx <= '0;
            end else if (w_fnext) begin
                r_fidx <= r_fidx + 3'd1;
            end
            if (w_fill0) begin
                r_fill0 <= dload;
            end
            if (w_install) begin
                r_state[w_req.idx] <= dmemWEN ? M : S;
            end
            if (w_flush_inv) begin
                r_state[r_fidx] <= I;
            end
            if (w_snp_upd) begin
                r_state[w_snp.idx] <= ccinv ? I : S;
            end
        end
    end

    // Tags and data need no reset: they are qualified by the line state.
    always_ff @(posedge CLK) begin
        if (w_install) begin
            r_tag[w_req.idx]   <= w_req.tag;
            r_data0[w_req.idx] <= r_fill0;
            r_data1[w_req.idx] <= dload;
        end
        if (w_hit && dmemWEN) begin
            if (w_req.blkoff) begin
                r_data1[w_req.idx] <= dmemstore;
            end else begin
                r_data0[w_req.idx] <= dmemstore;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache
// Purpose  : Directed self-checking bench for dcache: cold load, store
//            upgrade, dirty eviction, M and S snoops, flush on halt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dmemREN, dmemWEN, halt;
    logic [31:0] dmemaddr, dmemstore, dmemload;
    logic        dhit, flushed;
    logic        dREN, dWEN, cctrans, ccwrite;
    logic [31:0] daddr, dstore;
    logic        dwait, ccwait, ccinv;
    logic [31:0] dload, ccsnoopaddr;

    int n_checks = 0;
    int n_fail   = 0;

    dcache #(.CPUID(0)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .dmemaddr    (dmemaddr),
        .dmemstore   (dmemstore),
        .dmemload    (dmemload),
        .dhit        (dhit),
        .halt        (halt),
        .flushed     (flushed),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .daddr       (daddr),
        .dstore      (dstore),
        .cctrans     (cctrans),
        .ccwrite     (ccwrite),
        .dwait       (dwait),
        .dload       (dload),
        .ccwait      (ccwait),
        .ccinv       (ccinv),
        .ccsnoopaddr (ccsnoopaddr)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Wait for a block-read word request, check it, then complete it.
    task automatic serve_read(input string tag, input logic [31:0] addr,
                              input logic [31:0] data, input logic wr);
        int k = 0;
        while (!dREN && k < 40) begin
            tick();
            k++;
        end
        check_eq({tag, "_dREN"}, {31'd0, dREN}, 32'd1);
        check_eq({tag, "_daddr"}, daddr, addr);
        check_eq({tag, "_cctrans"}, {31'd0, cctrans}, 32'd1);
        check_eq({tag, "_ccwrite"}, {31'd0, ccwrite}, {31'd0, wr});
        dload = data;
        dwait = 1'b0;
        tick();
        dwait = 1'b1;
        dload = '0;
    endtask

    // Wait for a write-back word, check address and data, then complete it.
    task automatic serve_write(input string tag, input logic [31:0] addr,
                               input logic [31:0] data);
        int k = 0;
        while (!dWEN && k < 40) begin
            tick();
            k++;
        end
        check_eq({tag, "_dWEN"}, {31'd0, dWEN}, 32'd1);
        check_eq({tag, "_daddr"}, daddr, addr);
        check_eq({tag, "_dstore"}, dstore, data);
        dwait = 1'b0;
        tick();
        dwait = 1'b1;
    endtask

    task automatic req(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] data);
        dmemREN   = ren;
        dmemWEN   = wen;
        dmemaddr  = addr;
        dmemstore = data;
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        dmemREN = 0; dmemWEN = 0; dmemaddr = '0; dmemstore = '0; halt = 0;
        dwait = 1'b1; dload = '0; ccwait = 0; ccinv = 0; ccsnoopaddr = '0;
        tick();
        tick();
        check_eq("rst_dhit", {31'd0, dhit}, 32'd0);
        check_eq("rst_dREN", {31'd0, dREN}, 32'd0);
        check_eq("rst_dWEN", {31'd0, dWEN}, 32'd0);
        check_eq("rst_daddr", daddr, 32'd0);
        check_eq("rst_cctrans", {31'd0, cctrans}, 32'd0);
        check_eq("rst_flushed", {31'd0, flushed}, 32'd0);
        nRST = 1'b1;
        tick();

        // Cold load 0x40 -> S.
        req(1, 0, 32'h40, 0);
        check_eq("cold_miss_dhit", {31'd0, dhit}, 32'd0);
        serve_read("cold_w0", 32'h40, 32'h1111_0040, 1'b0);
        serve_read("cold_w1", 32'h44, 32'h1111_0044, 1'b0);
        check_eq("cold_hit", {31'd0, dhit}, 32'd1);
        check_eq("cold_load", dmemload, 32'h1111_0040);
        req(1, 0, 32'h44, 0);
        check_eq("cold_load_w1", dmemload, 32'h1111_0044);

        // Store to the S line: BusRdX refetch, then hit.
        req(0, 1, 32'h44, 32'h0000_DEAD);
        check_eq("st_s_miss", {31'd0, dhit}, 32'd0);
        serve_read("rdx_w0", 32'h40, 32'h2222_0040, 1'b1);
        serve_read("rdx_w1", 32'h44, 32'h2222_0044, 1'b1);
        check_eq("st_hit", {31'd0, dhit}, 32'd1);
        tick();
        req(1, 0, 32'h44, 0);
        check_eq("st_reload", dmemload, 32'h0000_DEAD);

        // Conflicting load 0x240 evicts the dirty line.
        req(1, 0, 32'h240, 0);
        serve_write("wb_w0", 32'h40, 32'h2222_0040);
        serve_write("wb_w1", 32'h44, 32'h0000_DEAD);
        serve_read("evict_w0", 32'h240, 32'h3333_0240, 1'b0);
        serve_read("evict_w1", 32'h244, 32'h3333_0244, 1'b0);
        check_eq("evict_load", dmemload, 32'h3333_0240);

        // Upgrade 0x240 line to M with 0xBEEF at 0x244.
        req(0, 1, 32'h244, 32'h0000_BEEF);
        serve_read("up_w0", 32'h240, 32'h4444_0240, 1'b1);
        serve_read("up_w1", 32'h244, 32'h4444_0244, 1'b1);
        tick();

        // Snoop of the M line (no invalidate) while a hitting load is held.
        req(1, 0, 32'h244, 0);
        ccwait = 1'b1; ccinv = 1'b0; ccsnoopaddr = 32'h240;
        #1;
        check_eq("snp_m_dhit_forced", {31'd0, dhit}, 32'd0);
        check_eq("snp_m_cctrans0", {31'd0, cctrans}, 32'd1);
        check_eq("snp_m_dstore0", dstore, 32'h4444_0240);
        dwait = 1'b0;
        tick();
        dwait = 1'b1;
        ccsnoopaddr = 32'h244;
        #1;
        check_eq("snp_m_dstore1", dstore, 32'h0000_BEEF);
        dwait = 1'b0;
        tick();
        dwait = 1'b1;
        ccsnoopaddr = 32'h80;
        #1;
        check_eq("snp_miss_cctrans", {31'd0, cctrans}, 32'd0);
        ccwait = 1'b0;
        #1;
        check_eq("snp_s_load_hit", {31'd0, dhit}, 32'd1);
        check_eq("snp_s_load_data", dmemload, 32'h0000_BEEF);
        req(0, 1, 32'h244, 32'h1);
        check_eq("snp_s_store_miss", {31'd0, dhit}, 32'd0);
        req(0, 0, 32'h0, 0);
        tick();

        // Fill set 1 (0x48) as S.
        req(1, 0, 32'h48, 0);
        serve_read("s1_w0", 32'h48, 32'h5555_0048, 1'b0);
        serve_read("s1_w1", 32'h4C, 32'h5555_004C, 1'b0);
        check_eq("s1_load", dmemload, 32'h5555_0048);

        // Load 0x80 misses; invalidate snoop on 0x48 lands during RD1.
        req(1, 0, 32'h80, 0);
        tick();
        check_eq("rd1_pending", {31'd0, dREN}, 32'd1);
        ccwait = 1'b1; ccinv = 1'b1; ccsnoopaddr = 32'h48;
        dwait = 1'b0;
        #1;
        check_eq("snp_s_cctrans", {31'd0, cctrans}, 32'd0);
        tick();
        dwait = 1'b1;
        tick();
        ccwait = 1'b0; ccinv = 1'b0;
        #1;
        serve_read("resume_w0", 32'h80, 32'h6666_0080, 1'b0);
        serve_read("resume_w1", 32'h84, 32'h6666_0084, 1'b0);
        check_eq("resume_load", dmemload, 32'h6666_0080);
        req(1, 0, 32'h48, 0);
        check_eq("inv_line_miss", {31'd0, dhit}, 32'd0);
        serve_read("refill_w0", 32'h48, 32'h5555_1048, 1'b0);
        serve_read("refill_w1", 32'h4C, 32'h5555_104C, 1'b0);

        // Dirty sets 2 and 5.
        req(0, 1, 32'h10, 32'hAAAA_0010);
        serve_read("s2_w0", 32'h10, 32'h6666_0010, 1'b1);
        serve_read("s2_w1", 32'h14, 32'h6666_0014, 1'b1);
        tick();
        req(0, 1, 32'h2C, 32'hBBBB_002C);
        serve_read("s5_w0", 32'h28, 32'h7777_0028, 1'b1);
        serve_read("s5_w1", 32'h2C, 32'h7777_002C, 1'b1);
        tick();
        req(0, 0, 32'h0, 0);

        // Flush on halt.
        halt = 1'b1;
        #1;
        check_eq("pre_flush", {31'd0, flushed}, 32'd0);
        serve_write("fl_s2_w0", 32'h10, 32'hAAAA_0010);
        serve_write("fl_s2_w1", 32'h14, 32'h6666_0014);
        serve_write("fl_s5_w0", 32'h28, 32'h7777_0028);
        serve_write("fl_s5_w1", 32'h2C, 32'hBBBB_002C);
        for (int k = 0; k < 40 && !flushed; k++) begin
            check_eq("flush_no_extra_wb", {31'd0, dWEN}, 32'd0);
            tick();
        end
        check_eq("flushed", {31'd0, flushed}, 32'd1);
        repeat (5) tick();
        check_eq("flushed_sticky", {31'd0, flushed}, 32'd1);
        check_eq("done_dWEN", {31'd0, dWEN}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
